// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic density estimator: level codes, lane
// indices and the threshold quantiser used by every lane.
package traffic_pkg;

  typedef enum logic [1:0] {
    LVL_NONE = 2'b00,
    LVL_LOW  = 2'b01,
    LVL_MED  = 2'b10,
    LVL_HIGH = 2'b11
  } level_t;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  function automatic level_t quant(input int x, input int th_low, input int th_med,
                                   input int th_high);
    if (x >= th_high) return LVL_HIGH;
    if (x >= th_med)  return LVL_MED;
    if (x >= th_low)  return LVL_LOW;
    return LVL_NONE;
  endfunction

endpackage

// File: rtl/lane_vehicle_counter.sv
// One approach lane: 2-flop synchroniser, debounce, rising-edge vehicle strobe
// and a saturating per-window vehicle counter with overflow flag.
module lane_vehicle_counter #(
  parameter int DEBOUNCE_CYC = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             det,
  input  logic             win_end,
  output logic [CNT_W-1:0] count_at_end,
  output logic             ovf_at_end
);

  localparam int              DW        = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DW-1:0]   DCNT_LAST = DW'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_p;
  logic             sync;
  logic             deb;
  logic [DW-1:0]    dcnt;
  logic             veh_evt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] vcnt_next;
  logic             vcnt_full;
  logic             ovf_pend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x, input logic inc);
    if (inc && (x != CNT_MAX)) return x + 1'b1;
    return x;
  endfunction

  assign sync      = sync_p[1];
  // The strobe fires in the cycle whose closing edge accepts the new high level.
  assign veh_evt   = sync & ~deb & (dcnt == DCNT_LAST);
  assign vcnt_full = (vcnt == CNT_MAX);
  assign vcnt_next = sat_inc(vcnt, veh_evt);

  assign count_at_end = vcnt_next;
  assign ovf_at_end   = ovf_pend | (veh_evt & vcnt_full);

  // Synchroniser and debounce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '0;
      deb    <= 1'b0;
      dcnt   <= '0;
    end else begin
      sync_p <= {sync_p[0], det};
      if (sync == deb) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        deb  <= sync;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Window accumulation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcnt     <= '0;
      ovf_pend <= 1'b0;
    end else if (win_end) begin
      vcnt     <= '0;
      ovf_pend <= 1'b0;
    end else begin
      vcnt <= vcnt_next;
      if (veh_evt && vcnt_full) ovf_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/traffic_density_estimator.sv
// Four-lane traffic density estimator: per-window vehicle counts quantised with
// downward hysteresis into registered 2-bit density levels.
module traffic_density_estimator
  import traffic_pkg::*;
#(
  parameter int WINDOW_CYC   = 6000,
  parameter int DEBOUNCE_CYC = 8,
  parameter int CNT_W        = 8,
  parameter int TH_LOW       = 3,
  parameter int TH_MED       = 8,
  parameter int TH_HIGH      = 15,
  parameter int HYST         = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       det_north,
  input  logic       det_south,
  input  logic       det_east,
  input  logic       det_west,
  output logic [1:0] sensor_north,
  output logic [1:0] sensor_south,
  output logic [1:0] sensor_east,
  output logic [1:0] sensor_west,
  output logic       sample_valid,
  output logic [3:0] cnt_overflow
);

  localparam int              WW       = (WINDOW_CYC > 2) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [WW-1:0]   WIN_LAST = WW'(WINDOW_CYC - 1);
  localparam logic [CNT_W:0]  HYST_EXT = (CNT_W + 1)'(HYST);

  logic [WW-1:0] win_cnt;
  logic          win_end;
  logic [3:0]    det_vec;
  level_t        lvl      [4];
  level_t        lvl_next [4];
  logic [3:0]    ovf_next;
  logic [3:0]    ovf_p1;
  logic          vld_p1;

  function automatic level_t next_level(input level_t cur, input level_t raw,
                                        input level_t down);
    if (raw > cur)  return raw;
    if (down < cur) return down;
    return cur;
  endfunction

  assign win_end = (win_cnt == WIN_LAST);
  assign det_vec = {det_west, det_east, det_south, det_north};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W:0]   cnt_hyst;

    lane_vehicle_counter #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .det          (det_vec[i]),
      .win_end      (win_end),
      .count_at_end (cnt),
      .ovf_at_end   (ovf)
    );

    // One extra bit so the hysteresis sum never wraps past a saturated count.
    assign cnt_hyst    = {1'b0, cnt} + HYST_EXT;
    assign lvl_next[i] = next_level(lvl[i],
                                    quant(int'(cnt), TH_LOW, TH_MED, TH_HIGH),
                                    quant(int'(cnt_hyst), TH_LOW, TH_MED, TH_HIGH));
    assign ovf_next[i] = ovf;
  end

  // Window end -> registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt <= '0;
      vld_p1  <= 1'b0;
      ovf_p1  <= '0;
      for (int i = 0; i < 4; i++) lvl[i] <= LVL_NONE;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      vld_p1  <= win_end;
      if (win_end) begin
        ovf_p1 <= ovf_next;
        for (int i = 0; i < 4; i++) lvl[i] <= lvl_next[i];
      end
    end
  end

  assign sensor_north = lvl[DIR_N];
  assign sensor_south = lvl[DIR_S];
  assign sensor_east  = lvl[DIR_E];
  assign sensor_west  = lvl[DIR_W];
  assign sample_valid = vld_p1;
  assign cnt_overflow = ovf_p1;

endmodule

// File: tb/tb_traffic_density_estimator.sv
// Directed bench for traffic_density_estimator with a 256-cycle window and
// hand-computed density levels per window.
module tb_traffic_density_estimator;

  logic       clk;
  logic       reset_n;
  logic       det_north, det_south, det_east, det_west;
  logic [1:0] sensor_north, sensor_south, sensor_east, sensor_west;
  logic       sample_valid;
  logic [3:0] cnt_overflow;

  int n_chk;
  int n_pass;

  traffic_density_estimator #(
    .WINDOW_CYC   (256),
    .DEBOUNCE_CYC (4),
    .CNT_W        (4),
    .TH_LOW       (2),
    .TH_MED       (4),
    .TH_HIGH      (6),
    .HYST         (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .det_north    (det_north),
    .det_south    (det_south),
    .det_east     (det_east),
    .det_west     (det_west),
    .sensor_north (sensor_north),
    .sensor_south (sensor_south),
    .sensor_east  (sensor_east),
    .sensor_west  (sensor_west),
    .sample_valid (sample_valid),
    .cnt_overflow (cnt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic logic veh_on(input int cyc, input int n);
    return (cyc >= 0) && ((cyc / 12) < n) && ((cyc % 12) < 6);
  endfunction

  // Called at the negedge of window cycle 0; returns at the negedge where the
  // next sample_valid is seen.
  task automatic run_window(input int nn, input int ns, input int ne, input int nw,
                            input bit glitch_n, input bit edge_n);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 600) begin
      if (cyc > 0 && sample_valid) begin
        done = 1'b1;
      end else begin
        if (glitch_n)
          det_north = (cyc < 60) ? ((cyc % 6) < 3) : veh_on(cyc - 60, nn);
        else
          det_north = veh_on(cyc, nn) | (edge_n && cyc >= 250 && cyc <= 255);
        det_south = veh_on(cyc, ns);
        det_east  = veh_on(cyc, ne);
        det_west  = veh_on(cyc, nw);
        @(negedge clk);
        cyc++;
      end
    end
    det_north = 1'b0;
    det_south = 1'b0;
    det_east  = 1'b0;
    det_west  = 1'b0;
    chk("win_len", cyc, 256);
  endtask

  // Counts negedges until sample_valid, noting any output activity before it.
  task automatic wait_quiet(output int cyc, output bit quiet);
    cyc   = 0;
    quiet = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!sample_valid &&
          ({sensor_north, sensor_south, sensor_east, sensor_west} != 8'h00 ||
           cnt_overflow != 4'h0))
        quiet = 1'b0;
    end while (!sample_valid && cyc < 600);
  endtask

  initial begin
    int cyc;
    bit quiet;
    n_chk     = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    det_north = 1'b0;
    det_south = 1'b0;
    det_east  = 1'b0;
    det_west  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sensors", int'({sensor_north, sensor_south, sensor_east, sensor_west}), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_ovf", int'(cnt_overflow), 0);
    reset_n = 1'b1;

    // Idle windows
    wait_quiet(cyc, quiet);
    chk("t1_first_len", cyc, 256);
    chk("t1_quiet", int'(quiet), 1);
    chk("t1_sensors", int'({sensor_north, sensor_south, sensor_east, sensor_west}), 0);
    wait_quiet(cyc, quiet);
    chk("t1_second_len", cyc, 256);

    // Glitches ignored, two vehicles -> low
    run_window(2, 0, 0, 0, 1'b1, 1'b0);
    chk("t2_north", int'(sensor_north), 1);
    chk("t2_others", int'({sensor_south, sensor_east, sensor_west}), 0);

    // Quantisation on south; east primed to high
    run_window(0, 5, 0, 0, 1'b0, 1'b0);
    chk("t3_south_5", int'(sensor_south), 2);
    chk("t3_others", int'({sensor_north, sensor_east, sensor_west}), 0);
    run_window(0, 6, 6, 0, 1'b0, 1'b0);
    chk("t3_south_6", int'(sensor_south), 3);
    chk("t4_east_prime", int'(sensor_east), 3);

    // Hysteresis on east
    run_window(0, 6, 5, 0, 1'b0, 1'b0);
    chk("t4_east_5_hold", int'(sensor_east), 3);
    run_window(0, 6, 4, 0, 1'b0, 1'b0);
    chk("t4_east_4_drop", int'(sensor_east), 2);
    run_window(0, 6, 0, 0, 1'b0, 1'b0);
    chk("t4_east_0_drop", int'(sensor_east), 0);
    run_window(0, 6, 4, 0, 1'b0, 1'b0);
    chk("t4_east_4_rise", int'(sensor_east), 2);

    // Saturation on west
    run_window(0, 6, 4, 20, 1'b0, 1'b0);
    chk("t5_west_sat", int'(sensor_west), 3);
    chk("t5_ovf_set", int'(cnt_overflow), 8);
    run_window(0, 6, 4, 3, 1'b0, 1'b0);
    chk("t5_west_3", int'(sensor_west), 2);
    chk("t5_ovf_clr", int'(cnt_overflow), 0);

    // Event landing on the window end cycle belongs to the closing window
    run_window(1, 6, 4, 0, 1'b0, 1'b1);
    chk("t6_edge_close", int'(sensor_north), 1);
    run_window(0, 6, 4, 0, 1'b0, 1'b0);
    chk("t6_edge_next", int'(sensor_north), 0);
    chk("t6_south_pre", int'(sensor_south), 3);

    // Asynchronous reset mid-window
    for (int c = 0; c < 100; c++) begin
      det_south = veh_on(c, 6);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("t6_rst_south", int'(sensor_south), 0);
    chk("t6_rst_east", int'(sensor_east), 0);
    chk("t6_rst_valid", int'(sample_valid), 0);
    @(negedge clk);
    det_south = 1'b0;
    reset_n   = 1'b1;
    wait_quiet(cyc, quiet);
    chk("t6_rst_len", cyc, 256);
    chk("t6_rst_quiet", int'(quiet), 1);
    chk("t6_rst_after", int'({sensor_north, sensor_south, sensor_east, sensor_west}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
